// File: rtl/oc8051_mpu_table.sv
// oc8051_mpu_table: per-page write/read/execute permission table for the
// secure 8051 XRAM path. Holds the bitmaps in a memory-mapped configuration
// window, checks unprivileged data and fetch accesses, and latches the first
// violation into sticky fault registers that drive an interrupt.
//
// Config handshake: an access starts when stb_i && cfg_sel_o && !ack_o and the
// strobe is not the same held strobe/address that was already acknowledged.
// ack_o pulses for exactly one cycle on the edge that commits the write;
// data_out_o carries the read byte only while ack_o is high.
module oc8051_mpu_table #(
    parameter int          PAGE_BITS = 8,
    parameter logic [15:0] CFG_BASE  = 16'hff80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        priv_lvl_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [15:0] xram_addr_i,
    input  logic [7:0]  xram_data_in_i,
    input  logic        fetch_stb_i,
    input  logic [15:0] fetch_addr_i,
    output logic        cfg_sel_o,
    output logic        ack_o,
    output logic [7:0]  data_out_o,
    output logic        wr_en_o,
    output logic        rd_en_o,
    output logic        ex_en_o,
    output logic        fault_irq_o
);

    localparam int NPAGES = 1 << PAGE_BITS;
    localparam int B      = NPAGES / 8;

    localparam logic [15:0] OFF_RD     = 16'(B);
    localparam logic [15:0] OFF_EX     = 16'(2 * B);
    localparam logic [15:0] OFF_LOCK   = 16'(3 * B);
    localparam logic [15:0] OFF_FSTAT  = 16'(3 * B + 1);
    localparam logic [15:0] OFF_FADDRL = 16'(3 * B + 2);
    localparam logic [15:0] OFF_FADDRH = 16'(3 * B + 3);
    localparam logic [15:0] OFF_END    = 16'(3 * B + 4);

    // Registered state
    logic [NPAGES-1:0] wr_map_q, wr_map_d;
    logic [NPAGES-1:0] rd_map_q, rd_map_d;
    logic [NPAGES-1:0] ex_map_q, ex_map_d;
    logic              lock_q, lock_d;
    logic [7:0]        fstat_q, fstat_d;
    logic [15:0]       faddr_q, faddr_d;
    logic              ack_q, ack_d;
    logic [7:0]        dout_q, dout_d;
    logic              irq_q, irq_d;
    logic              stb_q, stb_d;
    logic              held_q, held_d;
    logic [15:0]       held_addr_q, held_addr_d;

    // Decode helpers
    logic [15:0]          off;
    logic [PAGE_BITS-1:0] dpage;
    logic [PAGE_BITS-1:0] fpage;
    logic                 acc;
    logic                 cfg_wr_ok;
    logic [3:0]           new_bits;
    logic [7:0]           rdata;
    logic [7:0]           fstat_clr;

    assign off       = xram_addr_i - CFG_BASE;
    assign cfg_sel_o = (xram_addr_i >= CFG_BASE) && (off < OFF_END);
    assign dpage     = xram_addr_i[15 -: PAGE_BITS];
    assign fpage     = fetch_addr_i[15 -: PAGE_BITS];

    assign wr_en_o = priv_lvl_i | wr_map_q[dpage];
    assign rd_en_o = priv_lvl_i | rd_map_q[dpage];
    assign ex_en_o = priv_lvl_i | ex_map_q[fpage];

    assign ack_o       = ack_q;
    assign data_out_o  = dout_q;
    assign fault_irq_o = irq_q;

    // Config access detection and fault classification for this cycle
    always_comb begin
        acc = stb_i && cfg_sel_o && !ack_q && !(held_q && (xram_addr_i == held_addr_q));
        cfg_wr_ok = acc && we_i && priv_lvl_i;
        new_bits = 4'b0000;
        // Unprivileged config write
        new_bits[3] = acc && we_i && !priv_lvl_i;
        // Execute violation
        new_bits[2] = fetch_stb_i && !priv_lvl_i && !ex_en_o;
        // Data read / write violation, first cycle of a non-config strobe only
        new_bits[1] = stb_i && !stb_q && !cfg_sel_o && !priv_lvl_i && !we_i && !rd_en_o;
        new_bits[0] = stb_i && !stb_q && !cfg_sel_o && !priv_lvl_i &&  we_i && !wr_en_o;
    end

    // Config read multiplexer over the whole window
    always_comb begin
        rdata = 8'h00;
        for (int k = 0; k < B; k++) begin
            if (off == 16'(k))         rdata = wr_map_q[8*k +: 8];
            if (off == 16'(B + k))     rdata = rd_map_q[8*k +: 8];
            if (off == 16'(2 * B + k)) rdata = ex_map_q[8*k +: 8];
        end
        if (off == OFF_LOCK)   rdata = {7'b0, lock_q};
        if (off == OFF_FSTAT)  rdata = fstat_q;
        if (off == OFF_FADDRL) rdata = faddr_q[7:0];
        if (off == OFF_FADDRH) rdata = faddr_q[15:8];
    end

    // Next-state: bitmaps, lock, fault capture and handshake bookkeeping
    always_comb begin
        wr_map_d = wr_map_q;
        rd_map_d = rd_map_q;
        ex_map_d = ex_map_q;
        lock_d   = lock_q;

        if (cfg_wr_ok && !lock_q) begin
            for (int k = 0; k < B; k++) begin
                if (off == 16'(k))         wr_map_d[8*k +: 8] = xram_data_in_i;
                if (off == 16'(B + k))     rd_map_d[8*k +: 8] = xram_data_in_i;
                if (off == 16'(2 * B + k)) ex_map_d[8*k +: 8] = xram_data_in_i;
            end
        end
        if (cfg_wr_ok && (off == OFF_LOCK) && xram_data_in_i[0]) lock_d = 1'b1;

        // W1C clear applies before any fault arriving on the same edge
        fstat_clr = fstat_q;
        if (cfg_wr_ok && (off == OFF_FSTAT)) fstat_clr = fstat_q & ~xram_data_in_i;

        fstat_d = fstat_clr;
        faddr_d = faddr_q;
        if (new_bits != 4'b0000) begin
            if (fstat_clr[3:0] == 4'b0000) begin
                fstat_d[3:0] = new_bits;
                // Data/config address wins over the fetch address
                faddr_d = (new_bits[3] | new_bits[1] | new_bits[0]) ? xram_addr_i : fetch_addr_i;
            end else begin
                fstat_d[3:0] = fstat_clr[3:0] | new_bits;
                fstat_d[7]   = 1'b1;
            end
        end
        fstat_d[6:4] = 3'b000;

        irq_d       = |fstat_d[3:0];
        ack_d       = acc;
        dout_d      = acc ? rdata : 8'h00;
        stb_d       = stb_i;
        held_d      = stb_i && cfg_sel_o && (acc || held_q);
        held_addr_d = acc ? xram_addr_i : held_addr_q;
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_map_q    <= '0;
            rd_map_q    <= '0;
            ex_map_q    <= '0;
            lock_q      <= 1'b0;
            fstat_q     <= 8'h00;
            faddr_q     <= 16'h0000;
            ack_q       <= 1'b0;
            dout_q      <= 8'h00;
            irq_q       <= 1'b0;
            stb_q       <= 1'b0;
            held_q      <= 1'b0;
            held_addr_q <= 16'h0000;
        end else begin
            wr_map_q    <= wr_map_d;
            rd_map_q    <= rd_map_d;
            ex_map_q    <= ex_map_d;
            lock_q      <= lock_d;
            fstat_q     <= fstat_d;
            faddr_q     <= faddr_d;
            ack_q       <= ack_d;
            dout_q      <= dout_d;
            irq_q       <= irq_d;
            stb_q       <= stb_d;
            held_q      <= held_d;
            held_addr_q <= held_addr_d;
        end
    end

endmodule

// File: tb/tb_oc8051_mpu_table.sv
// Self-checking bench for oc8051_mpu_table (default PAGE_BITS=8, CFG_BASE=ff80).
module tb_oc8051_mpu_table;

    localparam int          NP   = 256;
    localparam int          NB   = NP / 8;
    localparam logic [15:0] BASE = 16'hff80;
    localparam int          WLEN = 3 * NB + 4;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // DUT inputs and outputs
    logic        priv_lvl, stb, we, fetch_stb;
    logic [15:0] xram_addr, fetch_addr;
    logic [7:0]  xram_data_in;
    logic        cfg_sel, ack, wr_en, rd_en, ex_en, fault_irq;
    logic [7:0]  data_out;

    oc8051_mpu_table dut (
        .clk            (clk),
        .rst            (rst),
        .priv_lvl_i     (priv_lvl),
        .stb_i          (stb),
        .we_i           (we),
        .xram_addr_i    (xram_addr),
        .xram_data_in_i (xram_data_in),
        .fetch_stb_i    (fetch_stb),
        .fetch_addr_i   (fetch_addr),
        .cfg_sel_o      (cfg_sel),
        .ack_o          (ack),
        .data_out_o     (data_out),
        .wr_en_o        (wr_en),
        .rd_en_o        (rd_en),
        .ex_en_o        (ex_en),
        .fault_irq_o    (fault_irq)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: permissions per page, fault registers, handshake memory
    bit          m_wr[NP];
    bit          m_rd[NP];
    bit          m_ex[NP];
    bit          m_lock;
    logic [7:0]  m_fstat;
    logic [15:0] m_faddr;
    logic        m_ack;
    logic [7:0]  m_dout;
    logic        m_stbq;
    logic        m_held;
    logic [15:0] m_held_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_wr[p] = 1'b0; m_rd[p] = 1'b0; m_ex[p] = 1'b0;
        end
        m_lock = 1'b0; m_fstat = 8'h00; m_faddr = 16'h0000;
        m_ack = 1'b0; m_dout = 8'h00; m_stbq = 1'b0;
        m_held = 1'b0; m_held_addr = 16'h0000;
    endtask

    function automatic logic in_win(input logic [15:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + WLEN);
    endfunction

    function automatic logic [7:0] m_byte(input int off);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (off < NB)          v[i] = m_wr[off*8 + i];
            else if (off < 2 * NB) v[i] = m_rd[(off - NB)*8 + i];
            else if (off < 3 * NB) v[i] = m_ex[(off - 2*NB)*8 + i];
        end
        if (off == 3 * NB)     v = {7'b0, m_lock};
        if (off == 3 * NB + 1) v = m_fstat;
        if (off == 3 * NB + 2) v = m_faddr[7:0];
        if (off == 3 * NB + 3) v = m_faddr[15:8];
        return v;
    endfunction

    // One clock cycle: check combinational outputs, predict, clock, check registered outputs
    task automatic cyc();
        logic        win, acc, wr_cmd;
        int          off, dp, fp;
        logic [3:0]  nf;
        logic [7:0]  fs, rv;
        logic [15:0] fa;
        #1;
        win = in_win(xram_addr);
        off = int'(xram_addr) - int'(BASE);
        dp  = int'(xram_addr) / 256;
        fp  = int'(fetch_addr) / 256;
        chk("cfg_sel", cfg_sel, win);
        chk("wr_en", wr_en, priv_lvl | m_wr[dp]);
        chk("rd_en", rd_en, priv_lvl | m_rd[dp]);
        chk("ex_en", ex_en, priv_lvl | m_ex[fp]);

        acc    = stb && win && !m_ack && !(m_held && xram_addr == m_held_addr);
        wr_cmd = acc && we && priv_lvl;
        rv     = acc ? m_byte(off) : 8'h00;
        nf     = 4'b0000;
        if (acc && we && !priv_lvl) nf[3] = 1'b1;
        if (fetch_stb && !priv_lvl && !m_ex[fp]) nf[2] = 1'b1;
        if (stb && !m_stbq && !win && !priv_lvl) begin
            if (we && !m_wr[dp]) nf[0] = 1'b1;
            if (!we && !m_rd[dp]) nf[1] = 1'b1;
        end
        fa = (nf[3] || nf[1] || nf[0]) ? xram_addr : fetch_addr;
        fs = m_fstat;
        if (wr_cmd && off == 3 * NB + 1) fs = fs & ~xram_data_in;

        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (nf != 4'b0000) begin
                if (fs[3:0] == 4'b0000) begin
                    fs = fs | {4'b0, nf};
                    m_faddr = fa;
                end else begin
                    fs = fs | {4'b0, nf} | 8'h80;
                end
            end
            fs[6:4] = 3'b000;
            m_fstat = fs;
            if (wr_cmd && !m_lock && off < 3 * NB) begin
                for (int i = 0; i < 8; i++) begin
                    if (off < NB)          m_wr[off*8 + i] = xram_data_in[i];
                    else if (off < 2 * NB) m_rd[(off - NB)*8 + i] = xram_data_in[i];
                    else                   m_ex[(off - 2*NB)*8 + i] = xram_data_in[i];
                end
            end
            if (wr_cmd && off == 3 * NB && xram_data_in[0]) m_lock = 1'b1;
            m_held      = stb && win && (acc || m_held);
            m_held_addr = acc ? xram_addr : m_held_addr;
            m_ack       = acc;
            m_dout      = rv;
            m_stbq      = stb;
        end
        chk("ack", ack, m_ack);
        chk("data_out", data_out, m_dout);
        chk("fault_irq", fault_irq, |m_fstat[3:0]);
    endtask

    // Driver tasks
    task automatic do_reset();
        rst = 1'b1; priv_lvl = 1'b0; stb = 1'b0; we = 1'b0; fetch_stb = 1'b0;
        xram_addr = 16'h0000; fetch_addr = 16'h0000; xram_data_in = 8'h00;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic cfg_rd(input logic p, input logic [15:0] a, output logic [7:0] d);
        priv_lvl = p; stb = 1'b1; we = 1'b0; xram_addr = a;
        cyc();
        d = data_out;
        stb = 1'b0;
        cyc();
    endtask

    task automatic cfg_wr(input logic p, input logic [15:0] a, input logic [7:0] d);
        priv_lvl = p; stb = 1'b1; we = 1'b1; xram_addr = a; xram_data_in = d;
        cyc();
        stb = 1'b0; we = 1'b0;
        cyc();
    endtask

    task automatic data_acc(input logic w, input logic [15:0] a);
        priv_lvl = 1'b0; stb = 1'b1; we = w; xram_addr = a;
        cyc();
        stb = 1'b0; we = 1'b0;
        cyc();
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return BASE + 16'($urandom_range(0, WLEN - 1));
            1:       return BASE + 16'(3 * NB + 1);
            default: return 16'($urandom);
        endcase
    endfunction

    logic [7:0] rd;
    int         acks;

    initial begin
        model_reset();
        do_reset();
        chk("reset_ack", ack, 1'b0);
        chk("reset_dout", data_out, 8'h00);
        chk("reset_irq", fault_irq, 1'b0);

        // Unprivileged read of an unmapped page
        priv_lvl = 1'b0; stb = 1'b1; we = 1'b0; xram_addr = 16'h1234;
        #1 chk("t1_rd_en", rd_en, 1'b0);
        cyc();
        chk("t1_irq", fault_irq, 1'b1);
        stb = 1'b0; cyc();
        cfg_rd(1'b1, 16'hffe1, rd); chk("t1_fstat", rd, 8'h02);
        cfg_rd(1'b1, 16'hffe2, rd); chk("t1_faddr_lo", rd, 8'h34);
        cfg_rd(1'b1, 16'hffe3, rd); chk("t1_faddr_hi", rd, 8'h12);
        cfg_wr(1'b1, 16'hffe1, 8'hff);
        chk("t1_irq_clr", fault_irq, 1'b0);

        // Grant write to page 8 and exercise it
        priv_lvl = 1'b1; stb = 1'b1; we = 1'b1; xram_addr = 16'hff81; xram_data_in = 8'h01;
        #1 chk("t2_ack_pre", ack, 1'b0);
        cyc();
        chk("t2_ack", ack, 1'b1);
        stb = 1'b0; we = 1'b0; cyc();
        chk("t2_ack_drop", ack, 1'b0);
        priv_lvl = 1'b0; we = 1'b1; xram_addr = 16'h0800;
        #1 chk("t2_wr_en_p8", wr_en, 1'b1);
        data_acc(1'b1, 16'h0800);
        chk("t2_no_fault", fault_irq, 1'b0);
        data_acc(1'b1, 16'h0900);
        cfg_rd(1'b1, 16'hffe1, rd); chk("t2_fstat", rd, 8'h01);
        cfg_wr(1'b1, 16'hffe1, 8'hff);

        // Lock freezes bitmaps
        cfg_wr(1'b1, 16'hffe0, 8'h01);
        cfg_wr(1'b1, 16'hffa0, 8'hff);
        cfg_rd(1'b1, 16'hffa0, rd); chk("t3_rd_byte0", rd, 8'h00);
        cfg_rd(1'b1, 16'hffe0, rd); chk("t3_lock", rd, 8'h01);

        // Overflow: exec fault then read fault
        fetch_stb = 1'b1; fetch_addr = 16'h4000; priv_lvl = 1'b0;
        cyc();
        fetch_stb = 1'b0;
        data_acc(1'b0, 16'h5000);
        cfg_rd(1'b1, 16'hffe1, rd); chk("t4_fstat", rd, 8'h86);
        cfg_rd(1'b1, 16'hffe2, rd); chk("t4_faddr_lo", rd, 8'h00);
        cfg_rd(1'b1, 16'hffe3, rd); chk("t4_faddr_hi", rd, 8'h40);
        cfg_wr(1'b1, 16'hffe1, 8'hff);
        cfg_rd(1'b1, 16'hffe1, rd); chk("t4_fstat_clr", rd, 8'h00);
        chk("t4_irq_clr", fault_irq, 1'b0);

        // Same-cycle data and exec faults
        priv_lvl = 1'b0; stb = 1'b1; we = 1'b0; xram_addr = 16'h2000;
        fetch_stb = 1'b1; fetch_addr = 16'h3000;
        cyc();
        stb = 1'b0; fetch_stb = 1'b0; cyc();
        cfg_rd(1'b1, 16'hffe1, rd); chk("t5_fstat", rd, 8'h06);
        cfg_rd(1'b1, 16'hffe3, rd); chk("t5_faddr_hi", rd, 8'h20);
        cfg_wr(1'b1, 16'hffe1, 8'hff);

        // Unprivileged config write held for 3 cycles
        priv_lvl = 1'b0; stb = 1'b1; we = 1'b1; xram_addr = 16'hff80; xram_data_in = 8'h5a;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            acks += int'(ack);
        end
        chk("t6_single_ack", acks, 1);
        stb = 1'b0; we = 1'b0; cyc();
        cfg_rd(1'b1, 16'hff80, rd); chk("t6_bitmap", rd, 8'h00);
        cfg_rd(1'b1, 16'hffe1, rd); chk("t6_fstat", rd, 8'h08);
        cfg_rd(1'b1, 16'hffe2, rd); chk("t6_faddr_lo", rd, 8'h80);
        cfg_rd(1'b1, 16'hffe3, rd); chk("t6_faddr_hi", rd, 8'hff);

        // Randomized traffic against the model, including mid-access resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 249) == 0);
            priv_lvl = ($urandom_range(0, 2) != 0);
            if (!stb) begin
                stb = 1'($urandom_range(0, 1));
                we = 1'($urandom_range(0, 1));
                xram_addr = rand_addr();
                xram_data_in = 8'($urandom);
            end else if ($urandom_range(0, 2) == 0) begin
                stb = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                xram_addr = rand_addr();
            end
            fetch_stb  = ($urandom_range(0, 2) == 0);
            fetch_addr = 16'($urandom);
            cyc();
        end
        rst = 1'b0; stb = 1'b0; fetch_stb = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/oc8051_mpu_table.md
# oc8051_mpu_table

Parametrised memory-protection table for the secure 8051 XRAM path. It holds per-page write, read and execute permission bitmaps in a memory-mapped configuration window. It checks unprivileged data and fetch accesses against those bitmaps, and latches the first violation (type and address) into sticky fault registers that drive an interrupt. A lock bit freezes the permission bitmaps until reset.

## Interface
- PAGE_BITS, 8: page index = addr[15:16-PAGE_BITS]; NPAGES = 2^PAGE_BITS; legal range 3..8.
- CFG_BASE, 16'hff80: first byte of config window; CFG_BASE + 3*B + 3 <= 16'hffff, where B = NPAGES/8.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- priv_lvl  in  1  1 = privileged; bypasses all permission checks
- stb  in  1  XRAM bus strobe, held by master until ack (config) or bus completion
- we  in  1  1 = write cycle, 0 = read; qualified by stb
- xram_addr  in  16  data-bus address
- xram_data_in  in  8  write data
- fetch_stb  in  1  one-cycle pulse per instruction fetch
- fetch_addr  in  16  fetch address, valid with fetch_stb
- cfg_sel  out  1  combinational; xram_addr inside config window
- ack  out  1  registered config-access acknowledge
- data_out  out  8  registered config read data
- wr_en, rd_en  out  1  combinational permission of xram_addr page; forced 1 when priv_lvl
- ex_en  out  1  combinational execute permission of fetch_addr page; forced 1 when priv_lvl
- fault_irq  out  1  registered; equals OR of FSTAT[3:0]

## Operation
- Window map (offsets from CFG_BASE): 0..B-1 WR bitmap, B..2B-1 RD bitmap, 2B..3B-1 EX bitmap, 3B LOCK, 3B+1 FSTAT, 3B+2 FADDR_LO, 3B+3 FADDR_HI.
- Bitmap byte k, bit i = page 8k+i.
- Config access when stb && cfg_sel && !ack:
  - Reads return the addressed byte; LOCK reads {7'b0, lock}.
  - Writes apply only if priv_lvl.
  - Bitmap writes are ignored while lock = 1.
  - LOCK write sets lock when data bit0 = 1; lock cannot be cleared except by rst.
  - FSTAT is write-1-to-clear.
  - FADDR is read-only.
- Unprivileged config write: no state change, ack still given, FSTAT[3] fault raised with address xram_addr.
- Data fault: first cycle of a strobe (stb && !stb_q), !cfg_sel, !priv_lvl, and we ? !wr_en : !rd_en. Sets FSTAT[0] (write) or FSTAT[1] (read).
- Exec fault: fetch_stb && !priv_lvl && !ex_en. Sets FSTAT[2].
- Fault capture:
  - If FSTAT[3:0] is 0 before the edge, FADDR <= faulting address. Data/config address has priority over fetch address when both fault in the same cycle; both type bits are set.
  - If FSTAT[3:0] is nonzero, the new type bits are OR'd in, FSTAT[7] (overflow) is set, and FADDR is kept.
- A W1C clear and a new fault in the same cycle: the clear applies first, then the new fault is captured as fresh. FSTAT[7] is set only if uncleared bits remain.
- FSTAT[6:4] read 0.

## Timing
- Reset values: bitmaps 0, lock 0, FSTAT 0, FADDR 0, ack 0, data_out 0, fault_irq 0, stb_q 0.
- cfg_sel, wr_en, rd_en, ex_en: same-cycle combinational.
- Config access: ack rises the cycle after stb && cfg_sel first seen, high exactly 1 cycle. The write commits on that same edge. data_out is valid while ack = 1 and is 0 otherwise. A strobe held across ack gives no second ack or commit; stb must drop or the address change.
- Fault registers and fault_irq update on the edge after the detecting cycle. Permission changes affect wr_en/rd_en/ex_en the cycle after commit.
- rst mid-access: ack drops next edge and all state clears; a held stb after rst deasserts is treated as a new access.

## Test plan
- Reset, priv_lvl=0, unprivileged read 16'h1234 -> rd_en=0; FSTAT=8'h02, FADDR=16'h1234, fault_irq=1 one cycle later.
- Privileged write 8'h01 to 16'hff81 (WR byte 1) -> ack 1 cycle later. Unprivileged write to 16'h0800 -> wr_en=1, no fault. Write to 16'h0900 -> FSTAT[0]=1.
- Privileged LOCK=1, then write 8'hff to 16'hffa0 -> ack, RD byte 0 stays 8'h00; readback of 16'hffa0 = 8'h00, LOCK reads 8'h01.
- Two unprivileged faults (exec at 16'h4000, then read at 16'h5000) -> FSTAT=8'h86, FADDR=16'h4000. Write 8'hff to FSTAT -> FSTAT=0, fault_irq=0.
- Same-cycle data-read fault 16'h2000 and exec fault 16'h3000 with FSTAT clear -> FSTAT=8'h06, FADDR=16'h2000, no overflow.
- Unprivileged write to 16'hff80 held 3 cycles -> single ack pulse, bitmap unchanged, FSTAT=8'h08, FADDR=16'hff80.
